// File: rtl/fg_drv_pkg.sv
// Shared types and the {f,g} -> {x1,x2,x3} encoder
// for the decoder stimulus driver.
package fg_drv_pkg;

  typedef logic [1:0] fg_code_t;

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  localparam fg_code_t FG_ILLEGAL = 2'b11;

  // Don't-care input bits are filled from the free counter
  function automatic logic [2:0] fg_encode(
    input fg_code_t   code,
    input logic [1:0] fc
  );
    logic [2:0] v;
    v = 3'b000;
    case (code)
      2'b00:   v = {fc[0], 2'b00};
      2'b10:   v = {fc[0], 2'b10};
      2'b01:   v = {fc[0], fc[1], 1'b1};
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fg_code_driver_if.sv
// Request handshake between a code producer
// and the decoder stimulus driver.
interface fg_code_driver_if;

  logic req_valid;
  logic req_ready;
  logic req_f;
  logic req_g;

  modport master (
    output req_valid,
    output req_f,
    output req_g,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_f,
    input  req_g,
    output req_ready
  );

endinterface

// File: rtl/fg_req_fifo.sv
// Small synchronous FIFO holding requested {f,g} codes.
// QDEPTH must be a power of two, at least 2.
module fg_req_fifo
  import fg_drv_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  fg_code_t wdata,
  output fg_code_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(QDEPTH);

  fg_code_t      mem [QDEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fg_code_driver.sv
// Queues requested {f,g} codes, drives the encoded vector to a
// registered decoder for HOLD_CYCLES, then checks its answer.
module fg_code_driver
  import fg_drv_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int QDEPTH      = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  fg_code_driver_if.slave  req,
  output logic             x1,
  output logic             x2,
  output logic             x3,
  input  logic             f_in,
  input  logic             g_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             illegal,
  output logic [7:0]       err_count
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t        state, state_n;
  logic [HW-1:0] hold, hold_n;
  logic [2:0]    vec, vec_n;
  fg_code_t      cur, cur_n;
  logic [1:0]    fc, fc_n;
  logic          done_n, err_n, illegal_n;
  logic [7:0]    cnt_n;

  fg_code_t      head;
  logic          full, empty;
  logic          push, pop, load;

  assign req.req_ready = !full;
  assign push = req.req_valid && !full;

  fg_req_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .wdata ({req.req_f, req.req_g}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n   = state;
    hold_n    = hold;
    vec_n     = vec;
    cur_n     = cur;
    fc_n      = fc;
    cnt_n     = err_count;
    done_n    = 1'b0;
    err_n     = 1'b0;
    illegal_n = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          if (head == FG_ILLEGAL) begin
            pop       = 1'b1;
            illegal_n = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (hold == HOLD_LAST) begin
          done_n = 1'b1;
          if ({f_in, g_in} != cur) begin
            err_n = 1'b1;
            if (err_count != 8'hff) cnt_n = err_count + 8'd1;
          end
          // Illegal heads are left for IDLE to retire
          load = !empty && (head != FG_ILLEGAL);
          if (!load) begin
            state_n = IDLE;
            vec_n   = 3'b000;
          end
        end else begin
          hold_n = hold + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      vec_n   = fg_encode(head, fc);
      cur_n   = head;
      fc_n    = fc + 2'd1;
      hold_n  = '0;
      state_n = DRIVE;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      hold      <= '0;
      vec       <= 3'b000;
      cur       <= 2'b00;
      fc        <= 2'b00;
      done      <= 1'b0;
      err       <= 1'b0;
      illegal   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      vec       <= vec_n;
      cur       <= cur_n;
      fc        <= fc_n;
      done      <= done_n;
      err       <= err_n;
      illegal   <= illegal_n;
      err_count <= cnt_n;
    end
  end

  assign {x1, x2, x3} = vec;
  assign busy = (state == DRIVE);

endmodule

// File: tb/tb_fg_code_driver.sv
// Directed bench for fg_code_driver with a registered
// behavioural decoder and optional stuck-at-0 fault on f.
module tb_fg_code_driver;
  import fg_drv_pkg::*;

  localparam int H = 8;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       x1, x2, x3;
  logic       f_in, g_in;
  logic       busy, done, err, illegal;
  logic [7:0] err_count;
  logic [1:0] dec;
  logic       fault;
  int         tests = 0;
  int         fails = 0;

  always #5 Clock = ~Clock;

  fg_code_driver_if req_if ();

  fg_code_driver #(
    .HOLD_CYCLES (H),
    .QDEPTH      (4)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .req       (req_if),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .f_in      (f_in),
    .g_in      (g_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .illegal   (illegal),
    .err_count (err_count)
  );

  // Registered decoder: x3 -> 01, x2 -> 10, else 00
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) dec <= 2'b00;
    else       dec <= x3 ? 2'b01 : (x2 ? 2'b10 : 2'b00);
  end
  assign f_in = fault ? 1'b0 : dec[1];
  assign g_in = dec[0];

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    req_if.req_valid = 1'b0;
    fault = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic set_req(input logic v, input logic [1:0] c);
    req_if.req_valid = v;
    {req_if.req_f, req_if.req_g} = c;
  endtask

  function automatic logic [2:0] b2b_vec(input int j);
    case (j)
      0:       return 3'b001;
      1:       return 3'b101;
      2:       return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  task automatic test_reset();
    tests++;
    if ({x1, x2, x3, busy, done, err, illegal} !== 7'b0 ||
        err_count !== 8'd0 || req_if.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_vals: got x=%b b=%b d=%b e=%b i=%b cnt=%0d rdy=%b want zeros rdy=1",
               {x1, x2, x3}, busy, done, err, illegal, err_count, req_if.req_ready);
    end
    step();
    Reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if ({busy, done, err, illegal} !== 4'b0) begin
        fails++;
        $display("FAIL reset_quiet: got bdei=%b want 0000", {busy, done, err, illegal});
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    set_req(1'b1, 2'b10);
    step();
    set_req(1'b0, 2'b00);
    for (int k = 1; k <= H + 1; k++) begin
      step();
      if (k == 1) begin
        tests++;
        if ({x1, x2, x3} !== 3'b010 || busy !== 1'b1) begin
          fails++;
          $display("FAIL single_x: got x=%b busy=%b want 010 1", {x1, x2, x3}, busy);
        end
      end
      if (k <= H) begin
        tests++;
        if (done !== 1'b0) begin
          fails++;
          $display("FAIL single_early_done: k=%0d got %b want 0", k, done);
        end
      end else begin
        tests++;
        if (done !== 1'b1 || err !== 1'b0) begin
          fails++;
          $display("FAIL single_done: got done=%b err=%b want 1 0", done, err);
        end
        tests++;
        if ({x1, x2, x3} !== 3'b000 || busy !== 1'b0) begin
          fails++;
          $display("FAIL single_idle: got x=%b busy=%b want 000 0", {x1, x2, x3}, busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int dn;
    dn = 0;
    apply_reset();
    set_req(1'b1, 2'b01);
    step();
    for (int n = 0; n <= 4 * H + 1; n++) begin
      if (n > 0) step();
      req_if.req_valid = (n < 3);
      if (done) dn++;
      if (n >= 1 && n <= 4 * H) begin
        tests++;
        if ({x1, x2, x3} !== b2b_vec((n - 1) / H) || busy !== 1'b1) begin
          fails++;
          $display("FAIL b2b_x: n=%0d got x=%b busy=%b want %b 1",
                   n, {x1, x2, x3}, busy, b2b_vec((n - 1) / H));
        end
      end
    end
    tests++;
    if (dn !== 4 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done: got %0d busy=%b want 4 0", dn, busy);
    end
  endtask

  task automatic test_fault();
    int dn, en;
    dn = 0;
    en = 0;
    apply_reset();
    fault = 1'b1;
    set_req(1'b1, 2'b10);
    step();
    step();
    step();
    set_req(1'b0, 2'b00);
    for (int k = 0; k < 60 && dn < 3; k++) begin
      step();
      if (done) dn++;
      if (err) en++;
      if (err && !done) begin
        tests++;
        fails++;
        $display("FAIL fault_err_alone: got err=1 done=0 want err with done");
      end
    end
    tests++;
    if (dn !== 3) begin
      fails++;
      $display("FAIL fault_timeout: got %0d done want 3", dn);
    end
    tests++;
    if (en !== 3 || err_count !== 8'd3) begin
      fails++;
      $display("FAIL fault_errs: got pulses=%0d cnt=%0d want 3 3", en, err_count);
    end
  endtask

  task automatic test_reset_mid_drive();
    set_req(1'b1, 2'b10);
    for (int k = 0; k < 5; k++) step();
    set_req(1'b0, 2'b00);
    tests++;
    if (busy !== 1'b1 || req_if.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_pre: got busy=%b rdy=%b want 1 0", busy, req_if.req_ready);
    end
    #3;
    Reset = 1'b1;
    #1;
    tests++;
    if ({x1, x2, x3} !== 3'b000 || err_count !== 8'd0 ||
        req_if.req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got x=%b cnt=%0d rdy=%b busy=%b want 000 0 1 0",
               {x1, x2, x3}, err_count, req_if.req_ready, busy);
    end
    step();
    Reset = 1'b0;
    fault = 1'b0;
    for (int k = 0; k < 2 * H + 4; k++) begin
      step();
      tests++;
      if ({busy, done, err, illegal} !== 4'b0) begin
        fails++;
        $display("FAIL mid_flush: k=%0d got bdei=%b want 0000", k, {busy, done, err, illegal});
      end
    end
  endtask

  task automatic test_queue_full();
    int acc, dn;
    acc = 0;
    dn = 0;
    apply_reset();
    set_req(1'b1, 2'b00);
    step();
    set_req(1'b0, 2'b00);
    step();
    set_req(1'b1, 2'b10);
    for (int k = 0; k < 6; k++) begin
      if (req_if.req_ready) acc++;
      step();
    end
    set_req(1'b0, 2'b00);
    tests++;
    if (acc !== 4 || req_if.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL qfull_accepts: got %0d rdy=%b want 4 0", acc, req_if.req_ready);
    end
    for (int k = 0; k < 60; k++) begin
      step();
      if (done) dn++;
    end
    tests++;
    if (dn !== 5 || busy !== 1'b0) begin
      fails++;
      $display("FAIL qfull_vectors: got %0d busy=%b want 5 0", dn, busy);
    end
  endtask

  task automatic test_illegal();
    int il, dn;
    il = 0;
    dn = 0;
    apply_reset();
    set_req(1'b1, 2'b11);
    step();
    set_req(1'b1, 2'b00);
    step();
    if (illegal) il++;
    tests++;
    if (illegal !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL illegal_pulse: got ill=%b busy=%b want 1 0", illegal, busy);
    end
    step();
    set_req(1'b0, 2'b00);
    if (illegal) il++;
    tests++;
    if ({x1, x2, x3} !== 3'b000 || busy !== 1'b1) begin
      fails++;
      $display("FAIL illegal_first_x: got x=%b busy=%b want 000 1", {x1, x2, x3}, busy);
    end
    for (int n = 3; n <= 2 * H + 3; n++) begin
      step();
      if (illegal) il++;
      if (done) dn++;
      if (n == H + 2) begin
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || {x1, x2, x3} !== 3'b100) begin
          fails++;
          $display("FAIL illegal_fc: got done=%b err=%b x=%b want 1 0 100",
                   done, err, {x1, x2, x3});
        end
      end
    end
    tests++;
    if (il !== 1 || dn !== 2) begin
      fails++;
      $display("FAIL illegal_counts: got ill=%0d done=%0d want 1 2", il, dn);
    end
  endtask

  initial begin
    Reset = 1'b1;
    fault = 1'b0;
    set_req(1'b0, 2'b00);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_fault();
    test_reset_mid_drive();
    test_queue_full();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
